mlp_layer_sequencer: RTL and testbench
======================================

Name: mlp_layer_sequencer

Overview:
- Handshake-driven controller that runs one inference through the weight-shared parallel MLP datapath.
- Accepts an input vector with a valid/ready handshake and loads it into the data register.
- Steps the layer index 0..M-1, allowing SETTLE cycles per layer for the neuron array to settle, then captures each layer result back into the data register.
- Presents the finished result with a valid/ready handshake. It replaces the free-running layer FSM and sits between the upstream source, the Data/Weight blocks and the downstream consumer.

Parameters:
- N, 4, neurons per layer (used only for assertion of consistency with the datapath; no datapath here)
- M, 3, number of layers, >=1
- SETTLE, 1, evaluation cycles per layer before capture, >=1
- CNT_W, 16, width of the completed-inference counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream input vector valid
- in_ready  out  1  controller can accept a vector
- out_valid  out  1  data register holds a finished result
- out_ready  in  1  downstream accepts the result
- load_initial  out  1  data register selects initial_inputs (else neuron outputs)
- layer_en  out  1  data register capture enable
- layer_idx  out  max(1,$clog2(M))  weight memory layer select
- busy  out  1  inference in progress (not IDLE)
- infer_count  out  CNT_W  completed inferences, wraps to 0

Behaviour:
- Reset: state IDLE, layer_idx=0, settle counter=0, infer_count=0. out_valid, busy, load_initial and layer_en are 0. in_ready=1 from the first cycle after reset.
- Reset asserted mid-inference aborts it the next edge. No out_valid is produced for the aborted run, and infer_count is unchanged by it.
- States: IDLE, EVAL, CAPTURE, DONE.
- IDLE:
  - in_ready=1, layer_idx=0.
  - load_initial=layer_en=in_valid (combinational), so the data register captures initial_inputs on the accept edge.
  - On in_valid, go to EVAL with settle counter=0.
- EVAL:
  - layer_en=0.
  - Settle counter increments each cycle.
  - After SETTLE cycles in EVAL, go to CAPTURE.
- CAPTURE (one cycle):
  - layer_en=1, load_initial=0, layer_idx unchanged, so the neuron outputs for layer L are captured.
  - If L==M-1, go to DONE; else layer_idx<=L+1 and go to EVAL.
- DONE:
  - out_valid=1, held with the data register stable until out_ready.
  - On out_valid&&out_ready: infer_count<=infer_count+1 (wraps at 2^CNT_W), go to IDLE, layer_idx<=0.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored, and no load occurs.
- out_ready while out_valid=0 is ignored.
- Latency: out_valid rises exactly M*(SETTLE+1) cycles after the accept edge. Back-to-back throughput is one inference per M*(SETTLE+1)+2 cycles (DONE handshake cycle plus IDLE accept cycle).
- layer_idx never exceeds M-1.
- For M=1, layer_idx is constantly 0 and the flow is one EVAL/CAPTURE pass.
- busy=1 in EVAL, CAPTURE and DONE.
- Outputs layer_idx, out_valid, in_ready and busy are decoded from registered state only. load_initial and layer_en may depend on in_valid in IDLE.

Decomposition:
- Package mlp_ctrl_pkg holds:
  - the state enum typedef (IDLE, EVAL, CAPTURE, DONE);
  - a function giving the layer index width max(1,$clog2(M));
  - a localparam-style latency helper M*(SETTLE+1) used by RTL assertions and the bench.
- One sub-module, settle_counter: a SETTLE-cycle down-counter with clear/start and a terminal-count pulse, instantiated once.

Test Plan:
- Reset then one vector (M=3, SETTLE=1), in_valid pulse at cycle 0, out_ready=1:
  - load_initial=layer_en=1 at cycle 0;
  - layer_en pulses at cycles 2, 4, 6 with layer_idx 0, 1, 2;
  - out_valid at cycle 6 after accept edge; infer_count=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid stays 1, layer_en stays 0, in_ready stays 0. Then out_ready=1 → one handshake, IDLE next cycle, infer_count increments once.
- in_valid held high continuously with out_ready=1 → accepts exactly every M*(SETTLE+1)+2=8 cycles. No load pulses while busy.
- Reset asserted during EVAL of layer 1 → next cycle IDLE, layer_idx=0, out_valid never asserted, infer_count unchanged.
- Parameter sweep M=1, SETTLE=3 → single capture 3 cycles after accept with layer_idx=0, out_valid at cycle 4.
- Wrap: CNT_W=2, run 5 inferences → infer_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mlp_ctrl_pkg.sv
// Shared types and helpers for the MLP layer sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: the controller state encoding, the layer-index width rule, and the
// accept-to-result latency used by assertions and by the bench.
package mlp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Width of an index over n items. Never narrower than one bit, so a
  // single-layer build still has a real layer_idx port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of clock edges from the accept edge to the edge that raises
  // out_valid: each layer spends `settle` cycles in EVAL plus one in CAPTURE.
  function automatic int unsigned infer_latency(input int m, input int settle);
    return $unsigned(m * (settle + 1));
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_settle_counter.sv
// SETTLE-cycle down-counter that times how long the neuron array settles.
// Latency: tc_o is high in the SETTLE-th cycle after the start_i edge.
// Backpressure: none; it runs to terminal count once started.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clear_i - park the counter (stop and zero); start_i has priority
//   start_i - load SETTLE-1 and begin counting on this edge
//   tc_o    - terminal count: high for one cycle in the last settle cycle
module settle_counter
  import mlp_ctrl_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic start_i,
  output logic tc_o
);

  localparam int             CW   = idx_w(SETTLE);
  localparam logic [CW-1:0]  LOAD = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // The count value reaches zero in the final settle cycle; run_q qualifies
  // it so an idle counter sitting at zero does not report terminal count.
  assign tc_o = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = LOAD;
      run_d = 1'b1;
    end else if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one inference through the weight-shared MLP datapath, layer by layer.
// Latency: out_valid rises M*(SETTLE+1) edges after the accept edge.
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid / in_ready      - upstream input-vector handshake
//   out_valid / out_ready    - downstream result handshake
//   load_initial, layer_en   - data register source select and capture enable
//   layer_idx                - weight memory layer select
//   busy                     - an inference is in progress
//   infer_count              - completed inferences, wrapping
module mlp_layer_sequencer
  import mlp_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  load_initial,
  output logic                  layer_en,
  output logic [idx_w(M)-1:0]   layer_idx,
  output logic                  busy,
  output logic [CNT_W-1:0]      infer_count
);

  localparam int                IDX_W    = idx_w(M);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(M - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    layer_idx_q, layer_idx_d;
  logic [CNT_W-1:0]    infer_count_q, infer_count_d;

  logic                settle_start;
  logic                settle_clear;
  logic                settle_tc;

  // Counter is parked whenever no layer is being evaluated; a start issued
  // on the same cycle (IDLE accept) takes priority inside the counter.
  assign settle_clear = (state_q == IDLE) || (state_q == DONE);

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (settle_clear),
    .start_i (settle_start),
    .tc_o    (settle_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      layer_idx_q   <= '0;
      infer_count_q <= '0;
    end else begin
      state_q       <= state_d;
      layer_idx_q   <= layer_idx_d;
      infer_count_q <= infer_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    layer_idx_d   = layer_idx_q;
    infer_count_d = infer_count_q;
    settle_start  = 1'b0;
    case (state_q)
      IDLE: begin
        layer_idx_d = '0;
        if (in_valid) begin
          state_d      = EVAL;
          settle_start = 1'b1;
        end
      end
      EVAL: begin
        if (settle_tc) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // layer_idx must stay put during CAPTURE so the captured outputs
        // belong to the layer that was just evaluated.
        if (layer_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          layer_idx_d  = layer_idx_q + IDX_W'(1);
          state_d      = EVAL;
          settle_start = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          infer_count_d = infer_count_q + CNT_W'(1);
          layer_idx_d   = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        layer_idx_d = '0;
      end
    endcase
  end

  // Output decode. Handshake and busy outputs come from registered state only;
  // the load strobe follows in_valid in IDLE so the data register captures
  // initial_inputs on the accept edge itself.
  always_comb begin
    in_ready     = (state_q == IDLE);
    out_valid    = (state_q == DONE);
    busy         = (state_q != IDLE);
    load_initial = (state_q == IDLE) && in_valid;
    layer_en     = ((state_q == IDLE) && in_valid) || (state_q == CAPTURE);
    layer_idx    = layer_idx_q;
    infer_count  = infer_count_q;
  end

`ifndef SYNTHESIS
  // Edges elapsed since the accept edge, for the latency check below.
  int unsigned lat_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      lat_q <= 0;
    end else if (state_q != DONE) begin
      lat_q <= lat_q + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (N >= 1 && M >= 1 && SETTLE >= 1 && CNT_W >= 1);
      assert (32'(layer_idx_q) <= 32'(M - 1));
      assert (!(settle_tc && state_q != EVAL));
      if (state_q == CAPTURE && state_d == DONE) begin
        assert (lat_q + 1 == infer_latency(M, SETTLE));
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: a default build (M=3, SETTLE=1)
// and a single-layer build with a 2-bit counter (M=1, SETTLE=3, CNT_W=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
module tb_mlp_layer_sequencer;
  import mlp_ctrl_pkg::*;

  localparam int unsigned LAT_A = infer_latency(3, 1);

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  // Instance A: M=3, SETTLE=1, CNT_W=16
  logic        rst_a, in_valid_a, out_ready_a;
  logic        in_ready_a, out_valid_a, load_initial_a, layer_en_a, busy_a;
  logic [1:0]  layer_idx_a;
  logic [15:0] infer_count_a;

  // Instance B: M=1, SETTLE=3, CNT_W=2
  logic        rst_b, in_valid_b, out_ready_b;
  logic        in_ready_b, out_valid_b, load_initial_b, layer_en_b, busy_b;
  logic [0:0]  layer_idx_b;
  logic [1:0]  infer_count_b;

  int wrap_exp [5] = '{1, 2, 3, 0, 1};

  mlp_layer_sequencer #(.N(4), .M(3), .SETTLE(1), .CNT_W(16)) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .in_valid     (in_valid_a),
    .in_ready     (in_ready_a),
    .out_valid    (out_valid_a),
    .out_ready    (out_ready_a),
    .load_initial (load_initial_a),
    .layer_en     (layer_en_a),
    .layer_idx    (layer_idx_a),
    .busy         (busy_a),
    .infer_count  (infer_count_a)
  );

  mlp_layer_sequencer #(.N(4), .M(1), .SETTLE(3), .CNT_W(2)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .in_valid     (in_valid_b),
    .in_ready     (in_ready_b),
    .out_valid    (out_valid_b),
    .out_ready    (out_ready_b),
    .load_initial (load_initial_b),
    .layer_en     (layer_en_b),
    .layer_idx    (layer_idx_b),
    .busy         (busy_b),
    .infer_count  (infer_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_ov;
    rst_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b0;
    step();
    step();

    // ---------------- reset state (A) ----------------
    rst_a = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready_a), 1);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_busy",      32'(busy_a), 0);
    chk("rst_load",      32'(load_initial_a), 0);
    chk("rst_layer_en",  32'(layer_en_a), 0);
    chk("rst_layer_idx", 32'(layer_idx_a), 0);
    chk("rst_count",     32'(infer_count_a), 0);
    step();

    // ---------------- abort by reset during EVAL of layer 1 ----------------
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    #1;
    chk("abort_load", 32'(load_initial_a), 1);
    step();                       // cycle 1: EVAL L0
    in_valid_a = 1'b0;
    step();                       // cycle 2: CAPTURE L0
    step();                       // cycle 3: EVAL L1
    #1;
    chk("abort_pre_idx",  32'(layer_idx_a), 1);
    chk("abort_pre_busy", 32'(busy_a), 1);
    chk("abort_pre_en",   32'(layer_en_a), 0);
    rst_a = 1'b1;
    step();
    #1;
    chk("abort_busy",     32'(busy_a), 0);
    chk("abort_idx",      32'(layer_idx_a), 0);
    chk("abort_in_ready", 32'(in_ready_a), 1);
    rst_a = 1'b0;
    seen_ov = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      if (out_valid_a) seen_ov = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen_ov), 0);
    chk("abort_count",        32'(infer_count_a), 0);
    step();

    // ---------------- single inference, out_ready=1 ----------------
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    #1;
    chk("t1_load_c0", 32'(load_initial_a), 1);
    chk("t1_en_c0",   32'(layer_en_a), 1);
    step();
    in_valid_a = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk($sformatf("t1_en_c%0d", c),   32'(layer_en_a), 32'(c == 2 || c == 4 || c == 6));
      chk($sformatf("t1_idx_c%0d", c),  32'(layer_idx_a), (c < 3) ? 0 : (c < 5) ? 1 : 2);
      chk($sformatf("t1_ov_c%0d", c),   32'(out_valid_a), 32'(c == 7));
      chk($sformatf("t1_busy_c%0d", c), 32'(busy_a), 1);
      step();
    end
    #1;
    chk("t1_count",    32'(infer_count_a), 1);
    chk("t1_in_ready", 32'(in_ready_a), 1);
    chk("t1_ov_low",   32'(out_valid_a), 0);
    step();

    // ---------------- backpressure ----------------
    in_valid_a = 1'b1; out_ready_a = 1'b0;
    #1;
    chk("t2_load", 32'(load_initial_a), 1);
    step();
    in_valid_a = 1'b0;
    repeat (LAT_A) step();        // now in cycle 7: DONE
    in_valid_a = 1'b1;            // must be ignored while busy
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t2_ov_k%0d", k),       32'(out_valid_a), 1);
      chk($sformatf("t2_en_k%0d", k),       32'(layer_en_a), 0);
      chk($sformatf("t2_in_ready_k%0d", k), 32'(in_ready_a), 0);
      chk($sformatf("t2_load_k%0d", k),     32'(load_initial_a), 0);
      step();
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    #1;
    chk("t2_ov_hs",    32'(out_valid_a), 1);
    chk("t2_count_hs", 32'(infer_count_a), 1);
    step();
    #1;
    chk("t2_idle_in_ready", 32'(in_ready_a), 1);
    chk("t2_idle_ov",       32'(out_valid_a), 0);
    chk("t2_count",         32'(infer_count_a), 2);
    step();
    #1;
    chk("t2_count_once", 32'(infer_count_a), 2);
    step();

    // ---------------- continuous in_valid, out_ready=1 ----------------
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    for (int c = 0; c < 24; c++) begin
      #1;
      chk($sformatf("t3_load_c%0d", c),  32'(load_initial_a), 32'(c % 8 == 0));
      chk($sformatf("t3_en_c%0d", c),    32'(layer_en_a),     32'(c % 2 == 0 && c % 8 != 8));
      chk($sformatf("t3_ready_c%0d", c), 32'(in_ready_a),     32'(c % 8 == 0));
      step();
    end
    in_valid_a = 1'b0;
    #1;
    chk("t3_count",    32'(infer_count_a), 5);
    chk("t3_in_ready", 32'(in_ready_a), 1);
    step();

    // ---------------- M=1, SETTLE=3, CNT_W=2 ----------------
    rst_b = 1'b0;
    #1;
    chk("b_rst_in_ready", 32'(in_ready_b), 1);
    chk("b_rst_count",    32'(infer_count_b), 0);
    step();
    in_valid_b = 1'b1; out_ready_b = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      chk($sformatf("b_load_c%0d", c), 32'(load_initial_b), 32'(c % 6 == 0));
      chk($sformatf("b_en_c%0d", c),   32'(layer_en_b),     32'(c % 6 == 0 || c % 6 == 4));
      chk($sformatf("b_idx_c%0d", c),  32'(layer_idx_b),    0);
      chk($sformatf("b_ov_c%0d", c),   32'(out_valid_b),    32'(c % 6 == 5));
      if (c % 6 == 0 && c > 0) begin
        chk($sformatf("b_count_c%0d", c), 32'(infer_count_b), 32'(wrap_exp[c / 6 - 1]));
      end
      step();
    end
    in_valid_b = 1'b0;
    #1;
    chk("b_count_c30", 32'(infer_count_b), 32'(wrap_exp[4]));
    chk("b_idle",      32'(busy_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
